ps2_kbd_ctrl: RTL and testbench
===============================

PS2_KBD_CTRL -- requirements
Module: ps2_kbd_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 2000000, meaning idle cycles allowed mid-sequence before abort.
REQ-002 Parameter FILTER_REPEAT, default 1, meaning 1 suppresses typematic repeat makes and 0 passes every make.
REQ-003 Port clk_i  input  1  system clock; all logic on rising edge.
REQ-004 Port reset_i  input  1  asynchronous, active-high reset.
REQ-005 Port rx_data_i  input  8  received PS/2 byte; valid only while rx_done_i=1.
REQ-006 Port rx_done_i  input  1  one-cycle strobe, byte available.
REQ-007 Port rx_en_o  output  1  receiver enable; permits a new frame to start.
REQ-008 Port evt_valid_o  output  1  key event available at FIFO head.
REQ-009 Port evt_ready_i  input  1  consumer accepts the head event.
REQ-010 Port evt_code_o  output  8  scan code of the head event.
REQ-011 Port evt_ext_o  output  1  head event carried the E0 prefix.
REQ-012 Port evt_brk_o  output  1  head event is a release (F0 prefix).
REQ-013 Port err_count_o  output  8  protocol/timeout error count; saturates at 255.
REQ-014 Port ovf_o  output  1  sticky flag: an event was dropped because the FIFO was full.
REQ-015 Port clr_i  input  1  synchronous clear of err_count_o and ovf_o.

Function
REQ-016 Decoder FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen); it advances only on cycles with rx_done_i=1.
REQ-017 Transitions from IDLE:
- E0 -> EXT.
- F0 -> BRK.
- AA, FA, EE, FE, 00, FF -> discarded, stay IDLE.
- Any other code (E1 included) -> emit make {ext=0, brk=0}, stay IDLE.
REQ-018 Transitions from EXT:
- F0 -> EXT_BRK.
- E0 -> stay EXT.
- Other -> emit make with ext=1, then IDLE.
REQ-019 Transitions from BRK:
- E0 or F0 -> protocol error, IDLE.
- Other -> emit break with ext=0, then IDLE.
REQ-020 Transitions from EXT_BRK:
- E0 or F0 -> protocol error, IDLE.
- Other -> emit break with ext=1, then IDLE.
REQ-021 Timeout counter behaviour:
- Counter clears on every rx_done_i and whenever the FSM is in IDLE.
- In a non-IDLE state, reaching TIMEOUT_CYCLES-1 forces IDLE and counts one error.
REQ-022 Each protocol error or timeout increments err_count_o by 1, saturating at 255; clr_i has priority over a same-cycle increment.
REQ-023 Repeat filter (FILTER_REPEAT=1) uses a held register {valid, ext, code}:
- A make equal to the held key while valid is dropped.
- Any other make is emitted and loads held.
- A break matching held clears valid.
- Other breaks leave held unchanged.
REQ-024 Emitted events are written into a 4-entry FIFO, 10 bits {ext, brk, code}, at the clock edge where rx_done_i is sampled high.
REQ-025 FIFO output timing:
- FIFO is first-word-fall-through.
- evt_valid_o = FIFO not empty.
- A write to an empty FIFO is visible on evt_* the following cycle.
REQ-026 Pop occurs when evt_valid_o and evt_ready_i are both 1; evt_* holds stable while evt_valid_o=1 and evt_ready_i=0.
REQ-027 FIFO boundary rules:
- Push when full with a same-cycle pop is accepted.
- Push when full without a pop drops the event and sets ovf_o.
- Pointers wrap modulo 4.
REQ-028 rx_en_o = 1 when the FIFO holds fewer than 4 entries, else 0; a frame already in progress may still complete and be handled per REQ-027.
REQ-029 clr_i does not affect the FSM, FIFO, or held register.

Reset
REQ-030 reset_i asserted at any time, including mid-sequence, forces all of the following:
- FSM to IDLE.
- Timeout counter to 0.
- FIFO empty (evt_valid_o=0, evt_code_o=0, evt_ext_o=0, evt_brk_o=0).
- held.valid=0, err_count_o=0, ovf_o=0, rx_en_o=1 (first cycle after release).

Verification
REQ-031 Bytes 1C, F0 1C -> events {1C,ext0,brk0} then {1C,ext0,brk1}, each visible one cycle after its final byte's rx_done_i.
REQ-032 Bytes E0 75, E0 F0 75 -> {75,ext1,brk0} then {75,ext1,brk1}; bytes 1C 1C 1C with FILTER_REPEAT=1 -> one event only.
REQ-033 Bytes F0 E0 -> err_count_o=1, no event, FSM IDLE; byte E0 then TIMEOUT_CYCLES idle cycles -> err_count_o increments and next byte 1C yields a non-extended make.
REQ-034 With evt_ready_i=0, send 5 distinct makes -> 4 queued, rx_en_o=0, ovf_o=1 after the 5th; then evt_ready_i=1 -> 4 events in order, rx_en_o returns to 1.
REQ-035 Full FIFO with simultaneous push and pop -> count stays 4, no overflow; reset_i pulse after E0 -> next byte 1C gives ext=0 and all outputs at reset values.

Source files
------------

// File: rtl/ps2_kbd_ctrl.sv
// rtl/ps2_kbd_ctrl.sv - PS/2 keyboard scan-code decoder with repeat filter and event FIFO
module ps2_kbd_ctrl #(
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int FILTER_REPEAT  = 1
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_done_i,
    output logic       rx_en_o,
    output logic       evt_valid_o,
    input  logic       evt_ready_i,
    output logic [7:0] evt_code_o,
    output logic       evt_ext_o,
    output logic       evt_brk_o,
    output logic [7:0] err_count_o,
    output logic       ovf_o,
    input  logic       clr_i
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] to_cnt;
    logic          timeout_hit;
    logic          dec_emit;
    logic          dec_ext;
    logic          dec_brk;
    logic          proto_err;
    logic          is_e0;
    logic          is_f0;
    logic          is_ignore;

    logic          held_valid;
    logic          held_ext;
    logic [7:0]    held_code;
    logic          held_match;
    logic          push;

    logic [9:0]    mem [4];
    logic [1:0]    wr_ptr;
    logic [1:0]    rd_ptr;
    logic [2:0]    count;
    logic          full;
    logic          pop;
    logic          wr_ok;
    logic [9:0]    head;

    assign is_e0       = (rx_data_i == 8'hE0);
    assign is_f0       = (rx_data_i == 8'hF0);
    assign timeout_hit = (state != S_IDLE) && !rx_done_i && (to_cnt == TO_LAST);

    always_comb begin
        is_ignore = 1'b0;
        case (rx_data_i)
            8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: is_ignore = 1'b1;
            default: is_ignore = 1'b0;
        endcase
    end

    always_comb begin
        next_state = state;
        dec_emit   = 1'b0;
        dec_ext    = 1'b0;
        dec_brk    = 1'b0;
        proto_err  = 1'b0;
        if (rx_done_i) begin
            case (state)
                S_IDLE: begin
                    if (is_e0)
                        next_state = S_EXT;
                    else if (is_f0)
                        next_state = S_BRK;
                    else if (!is_ignore)
                        dec_emit = 1'b1;
                end
                S_EXT: begin
                    if (is_f0) begin
                        next_state = S_EXT_BRK;
                    end else if (!is_e0) begin
                        dec_emit   = 1'b1;
                        dec_ext    = 1'b1;
                        next_state = S_IDLE;
                    end
                end
                S_BRK: begin
                    next_state = S_IDLE;
                    if (is_e0 || is_f0) begin
                        proto_err = 1'b1;
                    end else begin
                        dec_emit = 1'b1;
                        dec_brk  = 1'b1;
                    end
                end
                default: begin
                    next_state = S_IDLE;
                    if (is_e0 || is_f0) begin
                        proto_err = 1'b1;
                    end else begin
                        dec_emit = 1'b1;
                        dec_ext  = 1'b1;
                        dec_brk  = 1'b1;
                    end
                end
            endcase
        end else if (timeout_hit) begin
            next_state = S_IDLE;
        end
    end

    // Only makes are filtered; breaks always pass so releases are never lost.
    assign held_match = held_valid && (held_ext == dec_ext) && (held_code == rx_data_i);
    assign push = dec_emit && !((FILTER_REPEAT != 0) && !dec_brk && held_match);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state       <= S_IDLE;
            to_cnt      <= '0;
            held_valid  <= 1'b0;
            held_ext    <= 1'b0;
            held_code   <= 8'h00;
            err_count_o <= 8'h00;
        end else begin
            state <= next_state;
            if (rx_done_i || state == S_IDLE || timeout_hit)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + 1'b1;

            if (dec_emit && FILTER_REPEAT != 0) begin
                if (!dec_brk && !held_match) begin
                    held_valid <= 1'b1;
                    held_ext   <= dec_ext;
                    held_code  <= rx_data_i;
                end else if (dec_brk && held_match) begin
                    held_valid <= 1'b0;
                end
            end

            if (clr_i)
                err_count_o <= 8'h00;
            else if ((proto_err || timeout_hit) && err_count_o != 8'hFF)
                err_count_o <= err_count_o + 8'h01;
        end
    end

    assign full  = (count == 3'd4);
    assign pop   = (count != 3'd0) && evt_ready_i;
    assign wr_ok = push && (!full || pop);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < 4; i++)
                mem[i] <= 10'h000;
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
            ovf_o  <= 1'b0;
        end else begin
            if (wr_ok) begin
                mem[wr_ptr] <= {dec_ext, dec_brk, rx_data_i};
                wr_ptr      <= wr_ptr + 2'd1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 2'd1;
            count <= count + {2'b00, wr_ok} - {2'b00, pop};
            if (clr_i)
                ovf_o <= 1'b0;
            else if (push && !wr_ok)
                ovf_o <= 1'b1;
        end
    end

    assign head        = mem[rd_ptr];
    assign evt_valid_o = (count != 3'd0);
    assign evt_code_o  = evt_valid_o ? head[7:0] : 8'h00;
    assign evt_brk_o   = evt_valid_o & head[8];
    assign evt_ext_o   = evt_valid_o & head[9];
    assign rx_en_o     = !full;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// tb/tb_ps2_kbd_ctrl.sv - self-checking bench for ps2_kbd_ctrl
module tb_ps2_kbd_ctrl;

    localparam int TO = 50;

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b1;
    logic [7:0] rx_data_i = 8'h00;
    logic       rx_done_i = 1'b0;
    logic       rx_en_o;
    logic       evt_valid_o;
    logic       evt_ready_i = 1'b1;
    logic [7:0] evt_code_o;
    logic       evt_ext_o;
    logic       evt_brk_o;
    logic [7:0] err_count_o;
    logic       ovf_o;
    logic       clr_i = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;
    logic [9:0] exp_q[$];
    logic [9:0] mon_exp;

    typedef struct {
        logic [7:0] b;
        logic       exp;
        logic [9:0] ev;
    } vec_t;
    vec_t tbl[$];

    ps2_kbd_ctrl #(.TIMEOUT_CYCLES(TO), .FILTER_REPEAT(1)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .rx_data_i(rx_data_i), .rx_done_i(rx_done_i),
        .rx_en_o(rx_en_o), .evt_valid_o(evt_valid_o), .evt_ready_i(evt_ready_i),
        .evt_code_o(evt_code_o), .evt_ext_o(evt_ext_o), .evt_brk_o(evt_brk_o),
        .err_count_o(err_count_o), .ovf_o(ovf_o), .clr_i(clr_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every accepted event is compared against the oldest expectation.
    always @(negedge clk_i) begin
        if (!reset_i && evt_valid_o && evt_ready_i) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_event: got %0h expected none", {evt_ext_o, evt_brk_o, evt_code_o});
            end else begin
                mon_exp = exp_q.pop_front();
                check("event", {22'd0, evt_ext_o, evt_brk_o, evt_code_o}, {22'd0, mon_exp});
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk_i); #1;
        rx_data_i = b;
        rx_done_i = 1'b1;
        @(posedge clk_i); #1;
        rx_done_i = 1'b0;
        rx_data_i = 8'h00;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk_i);
            n++;
        end
        @(posedge clk_i); #1;
        check(name, exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, evt_valid_o, 1'b0);
        check({tag, "_code"}, evt_code_o, 8'h00);
        check({tag, "_ext"}, evt_ext_o, 1'b0);
        check({tag, "_brk"}, evt_brk_o, 1'b0);
        check({tag, "_err"}, err_count_o, 8'h00);
        check({tag, "_ovf"}, ovf_o, 1'b0);
        check({tag, "_rx_en"}, rx_en_o, 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tbl.push_back('{8'h1C, 1'b1, 10'h01C});
        tbl.push_back('{8'hF0, 1'b0, 10'h000});
        tbl.push_back('{8'h1C, 1'b1, 10'h11C});
        tbl.push_back('{8'hE0, 1'b0, 10'h000});
        tbl.push_back('{8'h75, 1'b1, 10'h275});
        tbl.push_back('{8'hE0, 1'b0, 10'h000});
        tbl.push_back('{8'hF0, 1'b0, 10'h000});
        tbl.push_back('{8'h75, 1'b1, 10'h375});
        tbl.push_back('{8'h1C, 1'b1, 10'h01C});
        tbl.push_back('{8'h1C, 1'b0, 10'h000});
        tbl.push_back('{8'h1C, 1'b0, 10'h000});
        tbl.push_back('{8'hF0, 1'b0, 10'h000});
        tbl.push_back('{8'h1C, 1'b1, 10'h11C});
        tbl.push_back('{8'h1C, 1'b1, 10'h01C});
        tbl.push_back('{8'hAA, 1'b0, 10'h000});
        tbl.push_back('{8'hFA, 1'b0, 10'h000});
        tbl.push_back('{8'hEE, 1'b0, 10'h000});
        tbl.push_back('{8'hFE, 1'b0, 10'h000});
        tbl.push_back('{8'h00, 1'b0, 10'h000});
        tbl.push_back('{8'hFF, 1'b0, 10'h000});
        tbl.push_back('{8'hE1, 1'b1, 10'h0E1});
        tbl.push_back('{8'hE0, 1'b0, 10'h000});
        tbl.push_back('{8'hE0, 1'b0, 10'h000});
        tbl.push_back('{8'h12, 1'b1, 10'h212});
        tbl.push_back('{8'hE0, 1'b0, 10'h000});
        tbl.push_back('{8'h12, 1'b0, 10'h000});
        tbl.push_back('{8'h12, 1'b1, 10'h012});
        tbl.push_back('{8'hF0, 1'b0, 10'h000});
        tbl.push_back('{8'hE0, 1'b0, 10'h000});
        tbl.push_back('{8'hE0, 1'b0, 10'h000});
        tbl.push_back('{8'hF0, 1'b0, 10'h000});
        tbl.push_back('{8'hE0, 1'b0, 10'h000});

        repeat (3) @(posedge clk_i);
        #1 reset_i = 1'b0;
        @(negedge clk_i);
        check_reset_outputs("reset");

        // Latency: event must not be visible before the sampling edge, and must be right after.
        evt_ready_i = 1'b0;
        @(posedge clk_i); #1;
        rx_data_i = 8'h2B;
        rx_done_i = 1'b1;
        @(negedge clk_i);
        check("lat_before", evt_valid_o, 1'b0);
        @(posedge clk_i); #1;
        rx_done_i = 1'b0;
        exp_q.push_back(10'h02B);
        @(negedge clk_i);
        check("lat_valid", evt_valid_o, 1'b1);
        check("lat_code", evt_code_o, 8'h2B);
        evt_ready_i = 1'b1;
        wait_drain("drain_latency");

        foreach (tbl[i]) begin
            send_byte(tbl[i].b);
            if (tbl[i].exp)
                exp_q.push_back(tbl[i].ev);
        end
        wait_drain("drain_table");
        check("err_after_table", err_count_o, 8'd2);

        send_byte(8'hE0);
        repeat (TO - 10) @(posedge clk_i);
        send_byte(8'h75);
        exp_q.push_back(10'h275);
        wait_drain("drain_no_timeout");
        check("err_no_timeout", err_count_o, 8'd2);

        send_byte(8'hE0);
        repeat (TO + 5) @(posedge clk_i);
        #1 check("err_timeout", err_count_o, 8'd3);
        send_byte(8'h1C);
        exp_q.push_back(10'h01C);
        wait_drain("drain_after_timeout");

        @(posedge clk_i); #1 clr_i = 1'b1;
        @(posedge clk_i); #1 clr_i = 1'b0;
        check("clr_err", err_count_o, 8'd0);

        evt_ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            send_byte(8'h30 + 8'(k));
            if (k < 4)
                exp_q.push_back(10'h030 + 10'(k));
            if (k == 2)
                check("rx_en_3", rx_en_o, 1'b1);
            if (k == 3) begin
                check("rx_en_full", rx_en_o, 1'b0);
                check("ovf_before", ovf_o, 1'b0);
            end
        end
        check("ovf_set", ovf_o, 1'b1);
        check("head_after_ovf", evt_code_o, 8'h30);

        @(posedge clk_i); #1 clr_i = 1'b1;
        @(posedge clk_i); #1 clr_i = 1'b0;
        check("clr_ovf", ovf_o, 1'b0);
        check("clr_keeps_fifo", evt_code_o, 8'h30);

        // Push into a full FIFO on the same edge as a pop.
        rx_data_i = 8'h35;
        rx_done_i = 1'b1;
        evt_ready_i = 1'b1;
        exp_q.push_back(10'h035);
        @(posedge clk_i); #1;
        rx_done_i = 1'b0;
        evt_ready_i = 1'b0;
        check("pushpop_rx_en", rx_en_o, 1'b0);
        check("pushpop_ovf", ovf_o, 1'b0);
        check("pushpop_head", evt_code_o, 8'h31);
        evt_ready_i = 1'b1;
        wait_drain("drain_full");
        check("rx_en_restored", rx_en_o, 1'b1);

        send_byte(8'hE0);
        #2 reset_i = 1'b1;
        #7 reset_i = 1'b0;
        @(negedge clk_i);
        check_reset_outputs("midreset");
        send_byte(8'h1C);
        exp_q.push_back(10'h01C);
        wait_drain("drain_after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
